// File: rtl/seq_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Start/Busy/Done handshake; results and divide-by-zero flag are held until the next completion.
module seq_divider #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           divzero
);

    localparam int CW = $clog2(2*W+1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg, state_next;
    logic [2*W-1:0] dvd_reg;
    logic [W-1:0]   dvs_reg;
    logic [W:0]     partial_reg;
    logic [2*W-1:0] quot_reg;
    logic [CW-1:0]  count_reg;
    logic [2*W-1:0] quotient_reg;
    logic [W-1:0]   remainder_reg;
    logic           done_reg;
    logic           divzero_reg;

    logic [W:0]     shifted;
    logic [W:0]     diff;
    logic           ge;
    logic           last;
    logic [W:0]     partial_next;
    logic [2*W-1:0] quot_next;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted      = {partial_reg[W-1:0], dvd_reg[2*W-1]};
        diff         = shifted - {1'b0, dvs_reg};
        ge           = (shifted >= {1'b0, dvs_reg});
        partial_next = ge ? diff : shifted;
        quot_next    = {quot_reg[2*W-2:0], ge};
        last         = (count_reg == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == IDLE) begin
            if (start) begin
                state_next = RUN;
            end
        end else begin
            if (last) begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        busy      = (state_reg == RUN);
        done      = done_reg;
        quotient  = quotient_reg;
        remainder = remainder_reg;
        divzero   = divzero_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            partial_reg   <= '0;
            quot_reg      <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            divzero_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    dvd_reg     <= dividend;
                    dvs_reg     <= divisor;
                    partial_reg <= '0;
                    quot_reg    <= '0;
                    count_reg   <= CW'(2*W);
                end
            end else begin
                dvd_reg     <= {dvd_reg[2*W-2:0], 1'b0};
                partial_reg <= partial_next;
                quot_reg    <= quot_next;
                count_reg   <= count_reg - CW'(1);
                if (last) begin
                    done_reg <= 1'b1;
                    // A zero divisor runs the full latency but reports a fixed result.
                    if (dvs_reg == '0) begin
                        quotient_reg  <= '1;
                        remainder_reg <= '0;
                        divzero_reg   <= 1'b1;
                    end else begin
                        quotient_reg  <= quot_next;
                        remainder_reg <= partial_next[W-1:0];
                        divzero_reg   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks for seq_divider at W=4, plus a random pass at W=8.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  dividend;
    logic [3:0]  divisor;
    logic [7:0]  quotient;
    logic [3:0]  remainder;
    logic        busy, done, divzero;

    logic        start8;
    logic [15:0] dividend8;
    logic [7:0]  divisor8;
    logic [15:0] quotient8;
    logic [7:0]  remainder8;
    logic        busy8, done8, divzero8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .divzero(divzero)
    );

    seq_divider #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .quotient(quotient8), .remainder(remainder8), .busy(busy8), .done(done8), .divzero(divzero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the W=4 divider idle; returns #1 after the edge following Done.
    task automatic run_op(input logic [7:0] dd, input logic [3:0] dv,
                          output logic [7:0] q, output logic [3:0] r, output logic z,
                          output int lat, output logic tok);
        tok = 1'b1;
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        if (busy !== 1'b1 || done !== 1'b0) tok = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) tok = 1'b0;
        end
        if (busy !== 1'b0) tok = 1'b0;
        q = quotient; r = remainder; z = divzero;
        @(posedge clk); #1;
        if (done !== 1'b0) tok = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic [7:0] dd, input logic [3:0] dv,
                            input logic [7:0] eq, input logic [3:0] er, input logic ez);
        logic [7:0] q; logic [3:0] r; logic z; int lat; logic tok;
        run_op(dd, dv, q, r, z, lat, tok);
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_timing"}, 32'(tok), 32'd1);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_dz"}, 32'(z), 32'(ez));
        $display("op %s: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, dd, dv, q, r, z, lat);
    endtask

    task automatic run_op8(input logic [15:0] dd, input logic [7:0] dv);
        int lat; logic tok; logic ok;
        tok = 1'b1;
        start8 = 1'b1; dividend8 = dd; divisor8 = dv;
        @(posedge clk); #1;
        start8 = 1'b0; dividend8 = 16'($urandom); divisor8 = 8'($urandom);
        if (busy8 !== 1'b1) tok = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done8 !== 1'b1 && busy8 !== 1'b1) tok = 1'b0;
        end
        if (busy8 !== 1'b0) tok = 1'b0;
        if (dv == 8'd0)
            ok = (quotient8 === 16'hFFFF) && (remainder8 === 8'd0) && (divzero8 === 1'b1);
        else
            ok = ((32'(quotient8) * 32'(dv) + 32'(remainder8)) == 32'(dd)) &&
                 (remainder8 < dv) && (divzero8 === 1'b0);
        chk("w8_rand", {29'd0, ok, (lat == 16), tok}, 32'd7);
        $display("op w8: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", dd, dv, quotient8, remainder8, divzero8, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] q; logic [3:0] r; logic z; int lat; logic tok; logic ok;
        int n, first, second; logic busy9, done9; logic [7:0] q_first; logic [3:0] r_first;
        int sweep_bad;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(divzero), 32'd0);
        $display("reset state: busy=%0d done=%0d q=%0d r=%0d dz=%0d", busy, done, quotient, remainder, divzero);
        rst_n = 1'b1;
        @(posedge clk); #1;

        check_op("d100_7", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);

        // Reset three edges into an operation.
        start = 1'b1; dividend = 8'd200; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_q", 32'(quotient), 32'd0);
        chk("midrst_r", 32'(remainder), 32'd0);
        chk("midrst_dz", 32'(divzero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("midrst_no_done", 32'(ok), 32'd1);
        $display("mid-run reset: outputs cleared, quiet after release=%0d", ok);
        check_op("after_rst", 8'd77, 4'd5, 8'd15, 4'd2, 1'b0);

        check_op("d255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        check_op("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
        check_op("d0_15", 8'd0, 4'd15, 8'd0, 4'd0, 1'b0);
        check_op("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
        check_op("d0_0", 8'd0, 4'd0, 8'd255, 4'd0, 1'b1);
        check_op("d200_0", 8'd200, 4'd0, 8'd255, 4'd0, 1'b1);
        check_op("d100_7b", 8'd100, 4'd7, 8'd14, 4'd2, 1'b0);

        // Start pulse during RUN must be ignored.
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 8'd255; divisor = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        n = 4;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", 32'(n), 32'd8);
        chk("ign_q", 32'(quotient), 32'd14);
        chk("ign_r", 32'(remainder), 32'd2);
        $display("start during run: done at t0+%0d q=%0d r=%0d", n, quotient, remainder);
        @(posedge clk); #1;
        chk("ign_idle", 32'({busy, done}), 32'd0);

        // Start held high: back-to-back operations.
        start = 1'b1; dividend = 8'd100; divisor = 4'd7;
        @(posedge clk); #1;
        dividend = 8'd255; divisor = 4'd15;
        n = 0; first = -1; second = -1; busy9 = 1'b0; done9 = 1'b1;
        q_first = '0; r_first = '0;
        while (second < 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 9) begin busy9 = busy; done9 = done; end
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = n; q_first = quotient; r_first = remainder;
                end else begin
                    second = n;
                end
            end
        end
        start = 1'b0;
        chk("held_first", 32'(first), 32'd8);
        chk("held_second", 32'(second), 32'd17);
        chk("held_q1", 32'(q_first), 32'd14);
        chk("held_r1", 32'(r_first), 32'd2);
        chk("held_restart", 32'({busy9, done9}), 32'd2);
        chk("held_q2", 32'(quotient), 32'd17);
        chk("held_r2", 32'(remainder), 32'd0);
        $display("held start: done at t0+%0d and t0+%0d, q2=%0d r2=%0d", first, second, quotient, remainder);
        @(posedge clk); #1;

        // Exhaustive W=4 sweep against the division invariant.
        sweep_bad = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(8'(a), 4'(b), q, r, z, lat, tok);
                if (b == 0)
                    ok = (q === 8'hFF) && (r === 4'd0) && (z === 1'b1);
                else
                    ok = ((int'(q) * b + int'(r)) == a) && (int'(r) < b) && (z === 1'b0);
                chk("sweep", {29'd0, ok, (lat == 8), tok}, 32'd7);
                if (!(ok && lat == 8 && tok)) sweep_bad++;
            end
        end
        $display("sweep W=4: 4096 pairs, %0d bad", sweep_bad);

        run_op8(16'd65535, 8'd1);
        run_op8(16'd65535, 8'd255);
        run_op8(16'd1234, 8'd0);
        for (int i = 0; i < 40; i++) begin
            run_op8(16'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
